pipe_stage_buf: RTL

Parametrised elastic pipeline-stage register for the MIPS pipeline, replacing fixed per-stage registers (D/E, E/M, M/W) with one reusable block. It holds up to two in-flight instructions (head plus skid entry) behind a valid/ready handshake, supports flush-to-bubble, and ages each instruction's Tnew (cycles until its result is ready) for the hazard unit. One instance sits between each pair of adjacent stages; the payload (IR, PC+8, operands, EXT, result type) is concatenated into one bus by the instantiating stage.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_stage_buf_if.sv | 16 +
 rtl/pipe_stage_buf_slot.sv | 43 ++++
 rtl/pipe_stage_buf.sv | 96 +++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage buffers: register-file widths,
// default Tnew width, the slot layout and the Tnew ageing helper.
package pipe_pkg;
  localparam int unsigned REG_A3_W   = 5;
  localparam logic [REG_A3_W-1:0] REG_ZERO = 5'd0;
  localparam int unsigned TNEW_W_DEF = 2;
  localparam int unsigned DATA_W_DEF = 101;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] data;
    logic [TNEW_W_DEF-1:0] tnew;
    logic [REG_A3_W-1:0]   a3;
  } slot_t;

  // The capturing stage spends one cycle, so Tnew drops by one but never wraps.
  function automatic int unsigned sat_dec(input int unsigned t);
    if (t == 0) return 0;
    return t - 1;
  endfunction
endpackage

// File: rtl/pipe_stage_buf_if.sv
// One valid/ready beat channel carrying payload, Tnew and destination register.
interface pipe_stage_buf_if #(
  parameter int unsigned DATA_W = 101,
  parameter int unsigned TNEW_W = 2
);
  import pipe_pkg::*;

  logic                valid;
  logic                ready;
  logic [DATA_W-1:0]   data;
  logic [TNEW_W-1:0]   tnew;
  logic [REG_A3_W-1:0] a3;

  modport master (output valid, data, tnew, a3, input  ready);
  modport slave  (input  valid, data, tnew, a3, output ready);
endinterface

// File: rtl/pipe_stage_buf_slot.sv
// Single clearable storage slot; clear (or reset) forces every field to zero.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 101,
  parameter int unsigned TNEW_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_i,
  input  logic                ld_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [TNEW_W-1:0]   tnew_i,
  input  logic [REG_A3_W-1:0] a3_i,
  output logic                vld_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [TNEW_W-1:0]   tnew_o,
  output logic [REG_A3_W-1:0] a3_o
);
  logic                vld_q;
  logic [DATA_W-1:0]   data_q;
  logic [TNEW_W-1:0]   tnew_q;
  logic [REG_A3_W-1:0] a3_q;

  always_ff @(posedge clk) begin
    if (!reset || clr_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      tnew_q <= '0;
      a3_q   <= REG_ZERO;
    end else if (ld_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
      tnew_q <= tnew_i;
      a3_q   <= a3_i;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign tnew_o = tnew_q;
  assign a3_o   = a3_q;
endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry elastic stage register (head + skid) with flush-to-bubble and
// Tnew ageing on capture. All outputs come straight from flops.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 101,
  parameter int unsigned TNEW_W = TNEW_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  pipe_stage_buf_if.slave   up,
  pipe_stage_buf_if.master  dn,
  output logic [1:0]        count
);
  logic                h_vld, s_vld;
  logic [DATA_W-1:0]   h_data, s_data;
  logic [TNEW_W-1:0]   h_tnew, s_tnew;
  logic [REG_A3_W-1:0] h_a3, s_a3;

  logic in_ready_q, in_ready_d;
  logic push, pop;
  logic h_ld, h_clr, s_ld, s_clr, h_from_s;
  logic [1:0] cnt_nxt;

  logic [DATA_W-1:0]   h_data_d;
  logic [TNEW_W-1:0]   h_tnew_d, in_tnew_dec;
  logic [REG_A3_W-1:0] h_a3_d;

  assign count       = {1'b0, h_vld} + {1'b0, s_vld};
  assign push        = up.valid & in_ready_q;
  assign pop         = h_vld & dn.ready;
  assign in_tnew_dec = TNEW_W'(sat_dec(32'(up.tnew)));
  assign cnt_nxt     = count + {1'b0, push} - {1'b0, pop};

  always_comb begin
    h_ld       = 1'b0;
    s_ld       = 1'b0;
    h_clr      = flush;
    s_clr      = flush;
    h_from_s   = 1'b0;
    in_ready_d = 1'b1;
    if (!flush) begin
      case (count)
        2'd0: h_ld = push;
        2'd1: begin
          if (push && pop) h_ld = 1'b1;
          else if (push)   s_ld = 1'b1;
          else if (pop)    h_clr = 1'b1;
        end
        2'd2: if (pop) begin
          h_ld     = 1'b1;
          h_from_s = 1'b1;
          s_clr    = 1'b1;
        end
        default: ;
      endcase
      in_ready_d = (cnt_nxt != 2'd2);
    end
  end

  // Skid entry already carries its aged Tnew; it is not decremented again on promotion.
  always_comb begin
    h_data_d = up.data;
    h_tnew_d = in_tnew_dec;
    h_a3_d   = up.a3;
    if (h_from_s) begin
      h_data_d = s_data;
      h_tnew_d = s_tnew;
      h_a3_d   = s_a3;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) in_ready_q <= 1'b1;
    else        in_ready_q <= in_ready_d;
  end

  pipe_slot #(.DATA_W(DATA_W), .TNEW_W(TNEW_W)) u_head (
    .clk(clk), .reset(reset), .clr_i(h_clr), .ld_i(h_ld),
    .data_i(h_data_d), .tnew_i(h_tnew_d), .a3_i(h_a3_d),
    .vld_o(h_vld), .data_o(h_data), .tnew_o(h_tnew), .a3_o(h_a3)
  );

  pipe_slot #(.DATA_W(DATA_W), .TNEW_W(TNEW_W)) u_skid (
    .clk(clk), .reset(reset), .clr_i(s_clr), .ld_i(s_ld),
    .data_i(up.data), .tnew_i(in_tnew_dec), .a3_i(up.a3),
    .vld_o(s_vld), .data_o(s_data), .tnew_o(s_tnew), .a3_o(s_a3)
  );

  assign up.ready = in_ready_q;
  assign dn.valid = h_vld;
  assign dn.data  = h_data;
  assign dn.tnew  = h_tnew;
  assign dn.a3    = h_a3;
endmodule
